// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg -- shared types and constants for the serial adder.
//   state_e  : FSM states (IDLE / RUN / DONE) built on the ENC_* encodings
//   cnt_w()  : width of the digit counter for a given digit count
package serial_adder_pkg;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] ENC_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] ENC_RUN  = 2'd1;
  localparam logic [STATE_W-1:0] ENC_DONE = 2'd2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = ENC_IDLE,
    ST_RUN  = ENC_RUN,
    ST_DONE = ENC_DONE
  } state_e;

  // A single-digit adder still needs a 1-bit counter to keep the ports legal.
  function automatic int cnt_w(input int ndig);
    return (ndig > 1) ? $clog2(ndig) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_fa_digit.sv
// fa_bit   -- 1-bit full adder cell.
//   a, b, cin : addends and carry-in
//   s, cout   : sum bit and carry-out
// fa_digit -- DIGIT_W-bit ripple adder built from fa_bit cells.
//   a, b [DIGIT_W] : digit addends
//   cin            : carry into bit 0
//   s [DIGIT_W]    : digit sum
//   cout           : carry out of the top bit
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module fa_digit #(
  parameter int DIGIT_W = 1
) (
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               cin,
  output logic [DIGIT_W-1:0] s,
  output logic               cout
);
  logic [DIGIT_W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < DIGIT_W; i++) begin : g_cell
    fa_bit u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (c[i]),
      .s   (s[i]),
      .cout(c[i+1])
    );
  end

  assign cout = c[DIGIT_W];
endmodule

// File: rtl/serial_adder.sv
// serial_adder -- digit-serial unsigned adder, DIGIT_W bits per clock.
//   clk, rst_n          : clock, async active-low reset
//   in_valid / in_ready : operand handshake (a, b, ci), accepted only in IDLE
//   out_valid/out_ready : result handshake (sum, co), held in DONE
//   sum, co             : {co,sum} = a + b + ci
//   ovf                 : signed overflow, only when SERIAL_ADDER_OVF_EN is defined
// WIDTH must be >= 2 and a multiple of DIGIT_W.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DIGIT_W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co
`ifdef SERIAL_ADDER_OVF_EN
  ,output logic            ovf
`endif
);

  localparam int NDIG  = WIDTH / DIGIT_W;
  localparam int CNT_W = cnt_w(NDIG);

  state_e state_q, state_d;

  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DIGIT_W-1:0] dig_s;
  logic               dig_co;
  logic               last_dig;
`ifdef SERIAL_ADDER_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  assign last_dig = (cnt_q == CNT_W'(NDIG - 1));

  fa_digit #(.DIGIT_W(DIGIT_W)) u_fa_digit (
    .a   (a_q[DIGIT_W-1:0]),
    .b   (b_q[DIGIT_W-1:0]),
    .cin (carry_q),
    .s   (dig_s),
    .cout(dig_co)
  );

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid)  state_d = ST_RUN;
      ST_RUN:  if (last_dig)  state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // in_ready is low for the whole DONE cycle, so the earliest re-accept is
  // the cycle after the result is taken.
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
  end

  // ---------------- datapath next-state ----------------
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    if (state_q == ST_IDLE && in_valid) begin
      a_d     = a;
      b_d     = b;
      carry_d = ci;
      cnt_d   = '0;
    end else if (state_q == ST_RUN) begin
      a_d     = a_q >> DIGIT_W;
      b_d     = b_q >> DIGIT_W;
      // New digit enters at the MSB end; after NDIG shifts digit 0 sits at the LSB.
      // Shift form instead of a concat so NDIG == 1 needs no special case.
      sum_d   = (sum_q >> DIGIT_W) | (WIDTH'(dig_s) << (WIDTH - DIGIT_W));
      carry_d = dig_co;
      cnt_d   = cnt_q + CNT_W'(1);
`ifdef SERIAL_ADDER_OVF_EN
      // Carry into the MSB is recovered as a^b^s of that bit.
      if (last_dig)
        ovf_d = a_q[DIGIT_W-1] ^ b_q[DIGIT_W-1] ^ dig_s[DIGIT_W-1] ^ dig_co;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // The final carry stays in carry_q through DONE and doubles as co.
  assign sum = sum_q;
  assign co  = carry_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder -- self-checking bench for serial_adder.
// Five instances: (W8,D1) (W8,D4) (W4,D1) (W4,D2) (W8,D8). Results are
// compared against plain a+b+ci arithmetic computed in the bench.
module tb_serial_adder;

  localparam int N = 5;

  function automatic int wof(input int k);
    case (k)
      2, 3:    return 4;
      default: return 8;
    endcase
  endfunction

  function automatic int dof(input int k);
    case (k)
      1:       return 4;
      3:       return 2;
      4:       return 8;
      default: return 1;
    endcase
  endfunction

  function automatic logic [7:0] msk(input int w);
    return 8'((1 << w) - 1);
  endfunction

  logic clk = 1'b0;
  logic rst_n;
  logic [N-1:0]      iv, rdy, ov, ordy, ci_v, co_v;
  logic [N-1:0][7:0] a_v, b_v, sum_v;
`ifdef SERIAL_ADDER_OVF_EN
  logic [N-1:0]      ovf_v;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < N; k++) begin : g_dut
    localparam int WL = wof(k);
    localparam int DL = dof(k);
    logic [WL-1:0] s;
    serial_adder #(.WIDTH(WL), .DIGIT_W(DL)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (iv[k]),
      .in_ready (rdy[k]),
      .a        (a_v[k][WL-1:0]),
      .b        (b_v[k][WL-1:0]),
      .ci       (ci_v[k]),
      .out_valid(ov[k]),
      .out_ready(ordy[k]),
      .sum      (s),
      .co       (co_v[k])
`ifdef SERIAL_ADDER_OVF_EN
      ,.ovf     (ovf_v[k])
`endif
    );
    assign sum_v[k] = 8'(s);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One full transaction on instance k; hold = DONE cycles with out_ready low.
  task automatic run_op(input int k, input logic [7:0] a, input logic [7:0] b,
                        input logic ci, input int hold);
    int w, nd, cnt;
    logic [8:0] tot;
    logic [7:0] es;
    logic       eco;
    logic       eovf;
    w   = wof(k);
    nd  = w / dof(k);
    tot = 9'(a & msk(w)) + 9'(b & msk(w)) + 9'(ci);
    es  = tot[7:0] & msk(w);
    eco = tot[w];
    eovf = (a[w-1] == b[w-1]) && (es[w-1] != a[w-1]);

    cnt = 0;
    while (rdy[k] !== 1'b1 && cnt < 50) begin @(negedge clk); cnt++; end
    chk("in_ready_idle", 32'(rdy[k]), 32'd1);

    iv[k] = 1'b1; a_v[k] = a; b_v[k] = b; ci_v[k] = ci;
    ordy[k] = 1'($urandom_range(0, 1));
    @(negedge clk);

    // RUN: operand inputs and out_ready toggled randomly must not matter
    cnt = 0;
    while (ov[k] !== 1'b1 && cnt < 40) begin
      iv[k]   = 1'($urandom_range(0, 1));
      a_v[k]  = 8'($urandom);
      b_v[k]  = 8'($urandom);
      ci_v[k] = 1'($urandom_range(0, 1));
      ordy[k] = 1'($urandom_range(0, 1));
      @(negedge clk);
      cnt++;
    end
    iv[k] = 1'b0; ordy[k] = 1'b0;
    chk("latency", 32'(cnt), 32'(nd));
    chk("sum", 32'(sum_v[k]), 32'(es));
    chk("co", 32'(co_v[k]), 32'(eco));
`ifdef SERIAL_ADDER_OVF_EN
    chk("ovf", 32'(ovf_v[k]), 32'(eovf));
`endif

    for (int i = 0; i < hold; i++) begin
      iv[k] = 1'b1; a_v[k] = 8'($urandom); b_v[k] = 8'($urandom);
      @(negedge clk);
      chk("hold_valid", 32'(ov[k]), 32'd1);
      chk("hold_ready", 32'(rdy[k]), 32'd0);
      chk("hold_sum", 32'(sum_v[k]), 32'(es));
      chk("hold_co", 32'(co_v[k]), 32'(eco));
    end

    iv[k] = 1'b0; ordy[k] = 1'b1;
    chk("done_ready", 32'(rdy[k]), 32'd0);
    @(negedge clk);
    ordy[k] = 1'($urandom_range(0, 1));
    chk("exit_valid", 32'(ov[k]), 32'd0);
    chk("exit_ready", 32'(rdy[k]), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    iv = '0; ordy = '0; ci_v = '0; a_v = '0; b_v = '0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < N; k++) begin
      chk("rst_valid", 32'(ov[k]), 32'd0);
      chk("rst_sum", 32'(sum_v[k]), 32'd0);
      chk("rst_co", 32'(co_v[k]), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
      chk("rst_ovf", 32'(ovf_v[k]), 32'd0);
`endif
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < N; k++) chk("rst_ready", 32'(rdy[k]), 32'd1);

    // 0xFF + 0x01 bit-serial: wraps to zero with carry out
    run_op(0, 8'hFF, 8'h01, 1'b0, 0);
    chk("ff01_sum", 32'(sum_v[0]), 32'h00);
    chk("ff01_co", 32'(co_v[0]), 32'd1);

    // 0x3C + 0x45 + 1 in nibbles: 0x82, signed overflow
    run_op(1, 8'h3C, 8'h45, 1'b1, 0);
    chk("3c45_sum", 32'(sum_v[1]), 32'h82);
    chk("3c45_co", 32'(co_v[1]), 32'd0);

    // backpressure: 5 cycles of out_ready low in DONE with in_valid noise
    run_op(0, 8'hA5, 8'h7E, 1'b1, 5);

    // reset in the third RUN cycle discards the partial result
    iv[0] = 1'b1; a_v[0] = 8'hC3; b_v[0] = 8'h99; ci_v[0] = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #2;
    chk("abort_valid", 32'(ov[0]), 32'd0);
    chk("abort_sum", 32'(sum_v[0]), 32'd0);
    chk("abort_co", 32'(co_v[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_ready", 32'(rdy[0]), 32'd1);
    run_op(0, 8'h10, 8'h20, 1'b0, 0);
    chk("after_abort_sum", 32'(sum_v[0]), 32'h30);
    chk("after_abort_co", 32'(co_v[0]), 32'd0);

    // exhaustive 4-bit, 1-bit and 2-bit digits
    for (int k = 2; k <= 3; k++)
      for (int x = 0; x < 16; x++)
        for (int y = 0; y < 16; y++)
          for (int c = 0; c < 2; c++)
            run_op(k, 8'(x), 8'(y), 1'(c), 0);

    // random traffic on the 8-bit configurations
    for (int i = 0; i < 60; i++) begin
      run_op(0, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 2));
      run_op(1, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 2));
      run_op(4, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end

    // boundary operands
    run_op(4, 8'h80, 8'h80, 1'b0, 0);
    run_op(1, 8'h7F, 8'h00, 1'b1, 1);
    run_op(0, 8'hFF, 8'hFF, 1'b1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
